// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: one outstanding memory read, in-order word queue to the core.
// Optional build macro IFETCH_HLT_STOP_EN stops fetching after an HLT word is queued.
module ifetch_seq #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        halted_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

`ifdef IFETCH_HLT_STOP_EN
  localparam logic [7:0] OPCODE_HLT = 8'hF4;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      target_q, target_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;

  logic [31:0]      word_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];

  logic             pop;
  logic             push;
  logic             hlt_hit;

  // Queue bookkeeping; a redirect empties the queue and overrides any pop or push.
  always_comb begin
    pop  = (count_q != '0) && inst_ready_i && !redirect_i;
    push = (state_q == WAIT) && mem_ack_i && !redirect_i;
`ifdef IFETCH_HLT_STOP_EN
    hlt_hit = push && (mem_rdata_i[7:0] == OPCODE_HLT);
`else
    hlt_hit = 1'b0;
`endif

    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    halted_d = halted_q;

    if (redirect_i) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      halted_d = halted_q | hlt_hit;
    end
  end

  // Fetch control; DISCARD keeps the abandoned address on the bus until memory answers.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    target_d = target_q;

    if (redirect_i) begin
      case (state_q)
        WAIT, DISCARD: begin
          if (mem_ack_i) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = redirect_pc_i;
          end else begin
            state_d  = DISCARD;
            req_d    = 1'b1;
            target_d = redirect_pc_i;
          end
        end
        default: begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = redirect_pc_i;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if ((count_q < FULL) && !halted_q) begin
            state_d = WAIT;
            req_d   = 1'b1;
          end
        end
        WAIT: begin
          if (mem_ack_i) begin
            addr_d = addr_q + 32'd4;
            if ((count_d < FULL) && !halted_d) begin
              state_d = WAIT;
              req_d   = 1'b1;
            end else begin
              state_d = IDLE;
              req_d   = 1'b0;
            end
          end
        end
        DISCARD: begin
          if (mem_ack_i) begin
            state_d = WAIT;
            req_d   = 1'b1;
            addr_d  = target_q;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Storage needs no reset; entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      word_mem[tail_q] <= mem_rdata_i;
      pc_mem[tail_q]   <= addr_q;
    end
  end

  always_comb begin
    mem_req_o    = req_q;
    mem_addr_o   = addr_q;
    inst_valid_o = (count_q != '0);
    inst_o       = inst_valid_o ? word_mem[head_q] : 32'h0;
    inst_pc_o    = inst_valid_o ? pc_mem[head_q]   : 32'h0;
    halted_o     = halted_q;
  end

endmodule

// File: tb/tb_ifetch_seq.sv
// Randomized self-checking bench for ifetch_seq against a queue-based fetch model.
// Honours IFETCH_HLT_STOP_EN when the build defines it.
module tb_ifetch_seq;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          N_CYCLES = 4000;
`ifdef IFETCH_HLT_STOP_EN
  localparam logic [7:0]  HLT_BYTE = 8'hF4;
`endif

  logic        clk_i;
  logic        reset_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halted_o;

  ifetch_seq #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .inst_valid_o(inst_valid_o),
    .inst_o(inst_o),
    .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halted_o(halted_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  // Reference model: words in flight to the core, plus what the memory bus should show.
  entry_t      m_q[$];
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_discarding;
  logic [31:0] m_target;
  logic        m_halted;

  int n_vectors     = 0;
  int n_miscompares = 0;
  int rdy_pct;
  int ack_pct;
  int redir_pct;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s at %0t: observed %08h, expected %08h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic force_reset);
    reset_i       = force_reset || ($urandom_range(0, 299) == 0);
    mem_ack_i     = ($urandom_range(0, 99) < ack_pct);
    inst_ready_i  = ($urandom_range(0, 99) < rdy_pct);
    redirect_i    = ($urandom_range(0, 99) < redir_pct);
    redirect_pc_i = 32'($urandom_range(0, 1023)) << 2;
    mem_rdata_i   = $urandom;
`ifdef IFETCH_HLT_STOP_EN
    if ($urandom_range(0, 15) == 0) mem_rdata_i[7:0] = HLT_BYTE;
`endif
  endtask

  // Advance the model by one clock edge using the inputs that were held across it.
  task automatic modelStep();
    int     size_before;
    logic   acked;
    entry_t e;
    if (reset_i) begin
      m_q.delete();
      m_req        = 1'b0;
      m_addr       = RESET_PC;
      m_discarding = 1'b0;
      m_halted     = 1'b0;
      return;
    end
    size_before = m_q.size();
    acked       = m_req && mem_ack_i;
    if (redirect_i) begin
      m_q.delete();
      m_halted = 1'b0;
      if (m_req && !mem_ack_i) begin
        m_discarding = 1'b1;
        m_target     = redirect_pc_i;
      end else begin
        m_discarding = 1'b0;
        m_req        = 1'b1;
        m_addr       = redirect_pc_i;
      end
      return;
    end
    if (size_before > 0 && inst_ready_i) void'(m_q.pop_front());
    if (!m_req) begin
      if (size_before < DEPTH && !m_halted) m_req = 1'b1;
    end else if (acked) begin
      if (m_discarding) begin
        m_discarding = 1'b0;
        m_addr       = m_target;
      end else begin
        e.word = mem_rdata_i;
        e.pc   = m_addr;
        m_q.push_back(e);
`ifdef IFETCH_HLT_STOP_EN
        if (mem_rdata_i[7:0] == HLT_BYTE) m_halted = 1'b1;
`endif
        m_addr = m_addr + 32'd4;
        if (m_q.size() >= DEPTH || m_halted) m_req = 1'b0;
      end
    end
  endtask

  task automatic checkAll();
    logic [31:0] exp_word;
    logic [31:0] exp_pc;
    exp_word = (m_q.size() > 0) ? m_q[0].word : 32'h0;
    exp_pc   = (m_q.size() > 0) ? m_q[0].pc   : 32'h0;
    checkOutput("mem_req",    {31'b0, mem_req_o},    {31'b0, m_req});
    checkOutput("mem_addr",   mem_addr_o,            m_addr);
    checkOutput("inst_valid", {31'b0, inst_valid_o}, {31'b0, (m_q.size() > 0)});
    checkOutput("inst",       inst_o,                exp_word);
    checkOutput("inst_pc",    inst_pc_o,             exp_pc);
    checkOutput("halted",     {31'b0, halted_o},     {31'b0, m_halted});
  endtask

  initial begin
    reset_i       = 1'b1;
    mem_ack_i     = 1'b0;
    mem_rdata_i   = 32'h0;
    inst_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    m_req         = 1'b0;
    m_addr        = RESET_PC;
    m_discarding  = 1'b0;
    m_target      = RESET_PC;
    m_halted      = 1'b0;
    rdy_pct       = 100;
    ack_pct       = 100;
    redir_pct     = 0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      // Early phases are fixed for streaming and fill-up; later ones are random mixes.
      if (cyc % 200 == 0) begin
        if (cyc == 0) begin
          rdy_pct = 100; ack_pct = 100; redir_pct = 0;
        end else if (cyc == 200) begin
          rdy_pct = 0;   ack_pct = 100; redir_pct = 0;
        end else begin
          case ($urandom_range(0, 4))
            0: begin rdy_pct = 100; ack_pct = 100; redir_pct = 2;  end
            1: begin rdy_pct = 5;   ack_pct = 80;  redir_pct = 3;  end
            2: begin rdy_pct = 50;  ack_pct = 30;  redir_pct = 10; end
            3: begin rdy_pct = 90;  ack_pct = 60;  redir_pct = 25; end
            default: begin rdy_pct = 30; ack_pct = 100; redir_pct = 5; end
          endcase
        end
      end
      applyStimulus(cyc < 2);
      @(posedge clk_i);
      modelStep();
      @(negedge clk_i);
      checkAll();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
